// File: rtl/hex_input_entry_pkg.sv
// Shared types and constants for the hex input entry block: word geometry,
// FSM encoding and the saturating nibble-count helper.
package hex_input_entry_pkg;

   localparam int WORD_W  = 32;
   localparam int NIBBLES = 8;
   localparam int NIB_W   = 4;

   typedef enum logic {
      ST_ENTRY = 1'b0,
      ST_HOLD  = 1'b1
   } entry_state_t;

   // Count of entered nibbles; sticks at NIBBLES once the word is full.
   function automatic logic [3:0] sat_inc(input logic [3:0] count);
      return (count >= 4'(NIBBLES)) ? 4'(NIBBLES) : count + 4'd1;
   endfunction

endpackage

// File: rtl/hex_input_entry_if.sv
// Word handoff to the CPU external input port: valid/ack handshake.
// master = hex entry block (producer), slave = CPU side (consumer).
interface hex_input_entry_if;
   import hex_input_entry_pkg::*;

   logic [WORD_W-1:0] inData;
   logic              inValid;
   logic              dataAck;

   modport master (output inData, output inValid, input dataAck);
   modport slave  (input inData, input inValid, output dataAck);

endinterface

// File: rtl/hex_input_entry_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-level debounce counter
// and a registered single-cycle pulse on each accepted press (0->1 only).
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  logic CLK,
   input  logic res,
   input  logic raw,
   output logic pulse
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             stable;
   logic [CNT_W-1:0] cnt;

   // Synchronize the raw level, then accept a change only after it has held
   // for DEBOUNCE_CYCLES consecutive samples; any bounce restarts the count.
   // NOTE: non-blocking assignments here so every flop samples the values from
   // before this edge; blocking would collapse the synchronizer into one stage.
   always_ff @(posedge CLK) begin
      if (!res) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         stable <= 1'b0;
         cnt    <= '0;
         pulse  <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         pulse <= 1'b0;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            stable <= sync2;
            cnt    <= '0;
            // stable differs from sync2 here, so sync2=1 means a 0->1 press
            pulse  <= sync2;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/hex_input_entry.sv
// Hex word entry: ENTER shifts the switch nibble into a 32-bit entry word,
// COMMIT hands the word to the CPU and waits for dataAck before accepting
// another commit. The live entry word is exported for display preview.
module hex_input_entry
   import hex_input_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  logic                CLK,
   input  logic                res,
   input  logic [NIB_W-1:0]    nibbleSw,
   input  logic                enterBtn,
   input  logic                commitBtn,
   hex_input_entry_if.master   cpu,
   output logic [WORD_W-1:0]   entryWord,
   output logic [3:0]          nibbleCount
);

   logic              enter_pulse;
   logic              commit_pulse;
   logic [WORD_W-1:0] eff_word;
   logic [3:0]        eff_count;
   entry_state_t      state;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_enter_db (
      .CLK   (CLK),
      .res   (res),
      .raw   (enterBtn),
      .pulse (enter_pulse)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_commit_db (
      .CLK   (CLK),
      .res   (res),
      .raw   (commitBtn),
      .pulse (commit_pulse)
   );

   // Word and count as they stand once this cycle's ENTER is applied; a
   // simultaneous COMMIT therefore includes the nibble entered on that edge.
   // NOTE: defaults assigned first so every path drives both outputs and no
   // latch is inferred.
   always_comb begin
      eff_word  = entryWord;
      eff_count = nibbleCount;
      if (enter_pulse) begin
         eff_word  = {entryWord[WORD_W-NIB_W-1:0], nibbleSw};
         eff_count = sat_inc(nibbleCount);
      end
   end

   // Entry register, count and ENTRY/HOLD handshake FSM; all outputs registered.
   always_ff @(posedge CLK) begin
      if (!res) begin
         state       <= ST_ENTRY;
         entryWord   <= '0;
         nibbleCount <= '0;
         cpu.inData  <= '0;
         cpu.inValid <= 1'b0;
      end else begin
         entryWord   <= eff_word;
         nibbleCount <= eff_count;
         case (state)
            ST_ENTRY: begin
               // Empty commits are ignored; dataAck has no meaning here.
               if (commit_pulse && (eff_count != 4'd0)) begin
                  cpu.inData  <= eff_word;
                  cpu.inValid <= 1'b1;
                  entryWord   <= '0;
                  nibbleCount <= '0;
                  state       <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               // inData frozen; commits are dropped, not queued.
               if (cpu.dataAck) begin
                  cpu.inValid <= 1'b0;
                  state       <= ST_ENTRY;
               end
            end
            default: state <= ST_ENTRY;
         endcase
      end
   end

endmodule

// File: tb/tb_hex_input_entry.sv
// Self-checking bench for hex_input_entry with a short debounce window.
// Reference model works at the level of "accepted presses": a press held for
// at least DEBOUNCE_CYCLES cycles counts once, and the word is plain shift
// arithmetic with a saturating count and a valid flag.
module tb_hex_input_entry;
   import hex_input_entry_pkg::*;

   localparam int D      = 4;
   localparam int SETTLE = D + 6;

   logic        CLK = 1'b0;
   logic        res = 1'b0;
   logic [3:0]  nibbleSw = 4'h0;
   logic        enterBtn = 1'b0;
   logic        commitBtn = 1'b0;
   logic [31:0] entryWord;
   logic [3:0]  nibbleCount;

   hex_input_entry_if bus ();

   hex_input_entry #(
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (3)
   ) dut (
      .CLK         (CLK),
      .res         (res),
      .nibbleSw    (nibbleSw),
      .enterBtn    (enterBtn),
      .commitBtn   (commitBtn),
      .cpu         (bus),
      .entryWord   (entryWord),
      .nibbleCount (nibbleCount)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic [31:0] m_word;
   logic [31:0] m_data;
   int          m_cnt;
   bit          m_valid;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic model_reset();
      m_word  = 32'h0;
      m_data  = 32'h0;
      m_cnt   = 0;
      m_valid = 1'b0;
   endtask

   // One accepted event: optional nibble entry, optional commit, optional ack.
   task automatic model_step(input bit ent, input bit com, input logic [3:0] nib, input bit ack);
      if (ent) begin
         m_word = (m_word << 4) | {28'h0, nib};
         m_cnt  = (m_cnt >= 8) ? 8 : m_cnt + 1;
      end
      if (!m_valid) begin
         if (com && m_cnt > 0) begin
            m_data  = m_word;
            m_valid = 1'b1;
            m_word  = 32'h0;
            m_cnt   = 0;
         end
      end else if (ack) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, " entryWord"},   entryWord,             m_word);
      check({tag, " nibbleCount"}, {28'h0, nibbleCount},  32'(m_cnt));
      check({tag, " inData"},      bus.inData,            m_data);
      check({tag, " inValid"},     {31'h0, bus.inValid},  {31'h0, m_valid});
   endtask

   task automatic apply_reset(input string tag, input bit drive_high);
      enterBtn    = drive_high;
      commitBtn   = drive_high;
      bus.dataAck = drive_high;
      res         = 1'b0;
      tick();
      res         = 1'b1;
      bus.dataAck = 1'b0;
      model_reset();
      check_all(tag);
   endtask

   // Hold the chosen buttons high for len cycles, release, let both the press
   // and the release fully settle, then compare against the model.
   task automatic do_press(input string tag, input bit e, input bit c,
                           input logic [3:0] nib, input int len);
      nibbleSw  = nib;
      enterBtn  = e;
      commitBtn = c;
      repeat (len) tick();
      enterBtn  = 1'b0;
      commitBtn = 1'b0;
      repeat (SETTLE) tick();
      if (len >= D) model_step(e, c, nib, 1'b0);
      check_all(tag);
   endtask

   task automatic do_ack(input string tag);
      bus.dataAck = 1'b1;
      tick();
      bus.dataAck = 1'b0;
      model_step(1'b0, 1'b0, 4'h0, 1'b1);
      check({tag, " inValid after ack edge"}, {31'h0, bus.inValid}, {31'h0, m_valid});
      repeat (2) tick();
      check_all(tag);
   endtask

   task automatic enter_seq(input string tag, input int first, input int last);
      for (int n = first; n <= last; n++) do_press(tag, 1'b1, 1'b0, 4'(n), D + 1);
   endtask

   initial begin
      bus.dataAck = 1'b0;
      model_reset();
      repeat (2) tick();
      res = 1'b1;
      check_all("power-on reset");

      // 1. reset clears everything, even with buttons and ack high
      do_press("t1 enter", 1'b1, 1'b0, 4'h5, D + 2);
      do_press("t1 commit", 1'b0, 1'b1, 4'h5, D + 2);
      do_press("t1 enter2", 1'b1, 1'b0, 4'h6, D + 2);
      apply_reset("t1 reset", 1'b1);
      repeat (2) tick();
      enterBtn  = 1'b0;
      commitBtn = 1'b0;
      repeat (SETTLE) tick();
      check_all("t1 short hold after reset");

      // 2. debounce: short excursion, latency, bounce
      do_press("t2 short", 1'b1, 1'b0, 4'hA, D - 1);
      nibbleSw = 4'hA;
      enterBtn = 1'b1;
      repeat (D + 2) tick();
      check("t2 before accept edge", entryWord, m_word);
      tick();
      check("t2 at accept edge", entryWord, (m_word << 4) | 32'hA);
      repeat (10 - (D + 3)) tick();
      enterBtn = 1'b0;
      repeat (SETTLE) tick();
      model_step(1'b1, 1'b0, 4'hA, 1'b0);
      check_all("t2 long");
      nibbleSw = 4'hB;
      enterBtn = 1'b1; tick();
      enterBtn = 1'b0; tick();
      enterBtn = 1'b1;
      repeat (4) tick();
      enterBtn = 1'b0;
      repeat (SETTLE) tick();
      model_step(1'b1, 1'b0, 4'hB, 1'b0);
      check_all("t2 bounce");

      // 3. full entry and handshake
      apply_reset("t3 reset", 1'b0);
      enter_seq("t3 enter", 1, 8);
      do_press("t3 commit", 1'b0, 1'b1, 4'h0, D + 1);
      check("t3 inData value", bus.inData, 32'h12345678);
      repeat (20) tick();
      check_all("t3 no ack");
      do_ack("t3 ack");

      // 4. overflow
      apply_reset("t4 reset", 1'b0);
      enter_seq("t4 enter", 1, 9);
      check("t4 overflow word", entryWord, 32'h23456789);

      // 5. ignored and dropped commits
      apply_reset("t5 reset", 1'b0);
      do_press("t5 empty commit", 1'b0, 1'b1, 4'h0, D + 1);
      enter_seq("t5 enter", 1, 8);
      do_press("t5 commit", 1'b0, 1'b1, 4'h0, D + 1);
      do_press("t5 hold enter", 1'b1, 1'b0, 4'hF, D + 1);
      do_press("t5 hold commit", 1'b0, 1'b1, 4'h0, D + 1);
      check("t5 inData frozen", bus.inData, 32'h12345678);
      do_ack("t5 ack");
      do_press("t5 commit after ack", 1'b0, 1'b1, 4'h0, D + 1);
      check("t5 inData new", bus.inData, 32'h0000000F);

      // 6. simultaneous pulses, then reset in HOLD
      apply_reset("t6 reset", 1'b0);
      do_press("t6 enter", 1'b1, 1'b0, 4'h3, D + 1);
      do_press("t6 both", 1'b1, 1'b1, 4'h7, D + 1);
      check("t6 inData both", bus.inData, 32'h00000037);
      apply_reset("t6 reset in hold", 1'b0);
      do_press("t6 enter after reset", 1'b1, 1'b0, 4'h1, D + 1);
      do_press("t6 commit after reset", 1'b0, 1'b1, 4'h0, D + 1);

      // randomized sequence of presses of random length and acks
      for (int i = 0; i < 60; i++) begin
         int          op;
         int          len;
         logic [3:0]  nib;
         op  = int'($urandom_range(0, 5));
         len = int'($urandom_range(1, 7));
         nib = 4'($urandom_range(0, 15));
         case (op)
            0, 1, 2: do_press("rand enter", 1'b1, 1'b0, nib, len);
            3:       do_press("rand commit", 1'b0, 1'b1, nib, len);
            4:       do_press("rand both", 1'b1, 1'b1, nib, len);
            default: do_ack("rand ack");
         endcase
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
